// File: rtl/snn_step_ctrl.sv
// Timestep sequencer for the SNN core: feeds one input vector per step, accumulates output
// spikes over a T_STEPS window, then reports the most active output neuron.
module snn_step_ctrl #(
    parameter int N_IN    = 16,
    parameter int N_OUT   = 8,
    parameter int T_STEPS = 16,
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN-1:0]          in_spk,
    output logic [N_IN-1:0]          core_in,
    output logic                     core_clr,
    output logic                     core_step,
    input  logic                     core_done,
    input  logic [N_OUT-1:0]         core_spk,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_OUT)-1:0] res_class,
    output logic [CNT_W-1:0]         res_count,
    output logic                     res_err
);
    // state     | meaning
    // IDLE      | waiting for start
    // CLEAR     | core_clr pulse, window counters cleared
    // WAIT_IN   | in_ready high, waiting for an input vector
    // STEP      | core_step pulse, watchdog restarted
    // WAIT_DONE | waiting for core_done, watchdog running
    // ARGMAX    | one counter compared per cycle
    // RESULT    | res_valid high until res_ready
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_IN,
        S_STEP,
        S_WAIT_DONE,
        S_ARGMAX,
        S_RESULT
    } state_t;

    localparam int CLS_W  = $clog2(N_OUT);
    localparam int STEP_W = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
    localparam int WD_W   = $clog2(TIMEOUT);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_STEPS - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [CLS_W-1:0]  LAST_IDX  = CLS_W'(N_OUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t              state_q, state_d;
    logic [N_IN-1:0]     core_in_q, core_in_d;
    logic [CNT_W-1:0]    cnt_q [N_OUT];
    logic [CNT_W-1:0]    cnt_d [N_OUT];
    logic [STEP_W-1:0]   step_idx_q, step_idx_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [CLS_W-1:0]    idx_q, idx_d;
    logic [CLS_W-1:0]    best_cls_q, best_cls_d;
    logic [CNT_W-1:0]    best_cnt_q, best_cnt_d;
    logic [CLS_W-1:0]    res_class_q, res_class_d;
    logic [CNT_W-1:0]    res_count_q, res_count_d;
    logic                res_err_q, res_err_d;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= S_IDLE;
            core_in_q   <= '0;
            cnt_q       <= '{default: '0};
            step_idx_q  <= '0;
            wd_q        <= '0;
            idx_q       <= '0;
            best_cls_q  <= '0;
            best_cnt_q  <= '0;
            res_class_q <= '0;
            res_count_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            core_in_q   <= core_in_d;
            cnt_q       <= cnt_d;
            step_idx_q  <= step_idx_d;
            wd_q        <= wd_d;
            idx_q       <= idx_d;
            best_cls_q  <= best_cls_d;
            best_cnt_q  <= best_cnt_d;
            res_class_q <= res_class_d;
            res_count_q <= res_count_d;
            res_err_q   <= res_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        core_in_d   = core_in_q;
        cnt_d       = cnt_q;
        step_idx_d  = step_idx_q;
        wd_d        = wd_q;
        idx_d       = idx_q;
        best_cls_d  = best_cls_q;
        best_cnt_d  = best_cnt_q;
        res_class_d = res_class_q;
        res_count_d = res_count_q;
        res_err_d   = res_err_q;

        // abort only redirects the FSM; window data is left for the next CLEAR to wipe
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_CLEAR;
                end
                S_CLEAR: begin
                    cnt_d      = '{default: '0};
                    step_idx_d = '0;
                    res_err_d  = 1'b0;
                    idx_d      = '0;
                    best_cls_d = '0;
                    best_cnt_d = '0;
                    state_d    = S_WAIT_IN;
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        core_in_d = in_spk;
                        state_d   = S_STEP;
                    end
                end
                S_STEP: begin
                    wd_d    = '0;
                    state_d = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (core_done) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            if (core_spk[i] && (cnt_q[i] != CNT_MAX)) begin
                                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                            end
                        end
                        if (step_idx_q == LAST_STEP) begin
                            state_d = S_ARGMAX;
                        end else begin
                            step_idx_d = step_idx_q + STEP_W'(1);
                            state_d    = S_WAIT_IN;
                        end
                    end else if (wd_q == WD_LAST) begin
                        res_err_d = 1'b1;
                        state_d   = S_ARGMAX;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                S_ARGMAX: begin
                    // strict compare keeps the lowest index on ties
                    if (cnt_q[idx_q] > best_cnt_q) begin
                        best_cnt_d = cnt_q[idx_q];
                        best_cls_d = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        res_class_d = best_cls_d;
                        res_count_d = best_cnt_d;
                        state_d     = S_RESULT;
                    end else begin
                        idx_d = idx_q + CLS_W'(1);
                    end
                end
                S_RESULT: begin
                    if (res_ready) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_WAIT_IN);
    assign core_clr  = (state_q == S_CLEAR);
    assign core_step = (state_q == S_STEP);
    assign busy      = (state_q != S_IDLE);
    assign res_valid = (state_q == S_RESULT);
    assign core_in   = core_in_q;
    assign res_class = res_class_q;
    assign res_count = res_count_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_snn_step_ctrl.sv
// Bench for snn_step_ctrl: a CNT_W=5 and a CNT_W=3 instance share one directed stimulus
// and are checked every cycle against a window-level model, plus literal result checks.
module tb_snn_step_ctrl;
    localparam int N_IN    = 16;
    localparam int N_OUT   = 8;
    localparam int T_STEPS = 16;
    localparam int TIMEOUT = 64;
    localparam int MAX5    = 31;
    localparam int MAX3    = 7;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_IN    = 2;
    localparam int P_STEP  = 3;
    localparam int P_DONE  = 4;
    localparam int P_ARG   = 5;
    localparam int P_RES   = 6;

    logic clk = 1'b0, rstb = 1'b0, start = 1'b0, abort = 1'b0;
    logic in_valid = 1'b0, core_done = 1'b0, res_ready = 1'b1;
    logic [N_IN-1:0]  in_spk = '0;
    logic [N_OUT-1:0] core_spk = '0;

    logic in_ready, core_clr, core_step, busy, res_valid, res_err;
    logic [N_IN-1:0] core_in;
    logic [2:0] res_class;
    logic [4:0] res_count;
    logic in_ready3, core_clr3, core_step3, busy3, res_valid3, res_err3;
    logic [N_IN-1:0] core_in3;
    logic [2:0] res_class3;
    logic [2:0] res_count3;

    always #5 clk = ~clk;

    snn_step_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .T_STEPS(T_STEPS), .CNT_W(5), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstb(rstb), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_spk(in_spk), .core_in(core_in),
        .core_clr(core_clr), .core_step(core_step), .core_done(core_done), .core_spk(core_spk),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_count(res_count), .res_err(res_err)
    );

    snn_step_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .T_STEPS(T_STEPS), .CNT_W(3), .TIMEOUT(TIMEOUT)) dut3 (
        .clk(clk), .rstb(rstb), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready3), .in_spk(in_spk), .core_in(core_in3),
        .core_clr(core_clr3), .core_step(core_step3), .core_done(core_done), .core_spk(core_spk),
        .busy(busy3), .res_valid(res_valid3), .res_ready(res_ready),
        .res_class(res_class3), .res_count(res_count3), .res_err(res_err3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // window-level reference: phase, saturating counts per width, argmax taken once at window end
    int m_ph = P_IDLE;
    int m_step = 0, m_wait = 0, m_left = 0, m_err = 0;
    int m_cnt5 [N_OUT];
    int m_cnt3 [N_OUT];
    int m_cls5 = 0, m_num5 = 0, m_cls3 = 0, m_num3 = 0;
    logic [N_IN-1:0] m_core_in = '0;

    task automatic model_enter_argmax();
        m_cls5 = 0; m_num5 = 0; m_cls3 = 0; m_num3 = 0;
        for (int i = 0; i < N_OUT; i++) begin
            if (m_cnt5[i] > m_num5) begin m_num5 = m_cnt5[i]; m_cls5 = i; end
            if (m_cnt3[i] > m_num3) begin m_num3 = m_cnt3[i]; m_cls3 = i; end
        end
        m_left = N_OUT;
        m_ph   = P_ARG;
    endtask

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_ph = P_IDLE; m_step = 0; m_wait = 0; m_left = 0; m_err = 0;
            m_core_in = '0;
            for (int i = 0; i < N_OUT; i++) begin m_cnt5[i] = 0; m_cnt3[i] = 0; end
        end else if (abort) begin
            m_ph = P_IDLE;
        end else begin
            case (m_ph)
                P_IDLE:  if (start) m_ph = P_CLEAR;
                P_CLEAR: begin
                    for (int i = 0; i < N_OUT; i++) begin m_cnt5[i] = 0; m_cnt3[i] = 0; end
                    m_step = 0; m_err = 0; m_ph = P_IN;
                end
                P_IN: if (in_valid) begin m_core_in = in_spk; m_ph = P_STEP; end
                P_STEP: begin m_wait = 0; m_ph = P_DONE; end
                P_DONE: begin
                    m_wait++;
                    if (core_done) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            if (core_spk[i]) begin
                                if (m_cnt5[i] < MAX5) m_cnt5[i]++;
                                if (m_cnt3[i] < MAX3) m_cnt3[i]++;
                            end
                        end
                        if (m_step == T_STEPS - 1) model_enter_argmax();
                        else begin m_step++; m_ph = P_IN; end
                    end else if (m_wait == TIMEOUT) begin
                        m_err = 1;
                        model_enter_argmax();
                    end
                end
                P_ARG: begin
                    m_left--;
                    if (m_left == 0) m_ph = P_RES;
                end
                P_RES: if (res_ready) m_ph = P_IDLE;
                default: m_ph = P_IDLE;
            endcase
        end
    end

    int n_step = 0;
    int n_clr  = 0;

    always @(negedge clk) begin
        check("busy", busy, m_ph != P_IDLE);
        check("in_ready", in_ready, m_ph == P_IN);
        check("core_clr", core_clr, m_ph == P_CLEAR);
        check("core_step", core_step, m_ph == P_STEP);
        check("res_valid", res_valid, m_ph == P_RES);
        check("core_in", core_in, m_core_in);
        check("busy3", busy3, m_ph != P_IDLE);
        check("in_ready3", in_ready3, m_ph == P_IN);
        check("core_clr3", core_clr3, m_ph == P_CLEAR);
        check("core_step3", core_step3, m_ph == P_STEP);
        check("res_valid3", res_valid3, m_ph == P_RES);
        check("core_in3", core_in3, m_core_in);
        if (m_ph == P_RES) begin
            check("res_class", res_class, m_cls5);
            check("res_count", res_count, m_num5);
            check("res_err", res_err, m_err);
            check("res_class3", res_class3, m_cls3);
            check("res_count3", res_count3, m_num3);
            check("res_err3", res_err3, m_err);
        end
        if (core_step) n_step++;
        if (core_clr) n_clr++;
    end

    // stimulus: a small core responder answers each core_step after done_dly cycles
    logic [N_OUT-1:0] spk_pat [T_STEPS];
    int done_dly = 1, withhold_at = -1, gap = 0, in_hold = 0;
    int pend = 0, resp_idx = 0, cyc = 0;
    int last_step_cyc = 0, start_cyc = 0, res_cyc = -1;
    int base_step = 0, base_clr = 0;

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        core_done = 1'b0;
        core_spk  = '0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                core_done = 1'b1;
                core_spk  = spk_pat[resp_idx % T_STEPS];
                resp_idx++;
            end
        end
        if (core_step) begin
            last_step_cyc = cyc;
            pend = (resp_idx == withhold_at) ? 0 : done_dly;
        end
        in_valid = (in_hold == 0) && ((cyc % (gap + 1)) == 0);
        in_spk   = N_IN'(cyc * 40503) ^ N_IN'(23130);
    endtask

    task automatic run_window(input int budget);
        pend = 0; resp_idx = 0;
        base_step = n_step; base_clr = n_clr;
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        res_cyc = -1;
        for (int k = 0; k < budget && res_cyc < 0; k++) begin
            tick();
            if (res_valid) res_cyc = cyc;
        end
        if (res_cyc < 0) check("res_valid_wait", 0, 1);
    endtask

    task automatic expect_res(input string tag, input int c5, input int n5,
                              input int c3, input int n3, input int err);
        check({tag, "_class"}, res_class, c5);
        check({tag, "_count"}, res_count, n5);
        check({tag, "_class3"}, res_class3, c3);
        check({tag, "_count3"}, res_count3, n3);
        check({tag, "_err"}, res_err, err);
    endtask

    initial begin
        int seen;
        for (int s = 0; s < T_STEPS; s++) spk_pat[s] = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_core_in", core_in, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_class", res_class, 0);
        check("rst_res_count", res_count, 0);
        check("rst_res_err", res_err, 0);
        tick(); tick();
        rstb = 1'b1;
        tick();

        // nominal: neuron 5 every step, neuron 2 on even steps
        for (int s = 0; s < T_STEPS; s++) spk_pat[s] = 8'h20 | ((s % 2 == 0) ? 8'h04 : 8'h00);
        run_window(200);
        check("t1_latency", res_cyc - start_cyc, 57);
        expect_res("t1", 5, 16, 2, 7, 0);
        check("t1_steps", n_step - base_step, 16);
        check("t1_clrs", n_clr - base_clr, 1);
        tick();

        // tie between neurons 1 and 6
        for (int s = 0; s < T_STEPS; s++) spk_pat[s] = (s % 2 == 0) ? 8'h40 : 8'h02;
        run_window(200);
        expect_res("t2", 1, 8, 1, 7, 0);
        tick();

        // silence, then saturation of neuron 3
        for (int s = 0; s < T_STEPS; s++) spk_pat[s] = 8'h00;
        run_window(200);
        expect_res("t3a", 0, 0, 0, 0, 0);
        tick();
        for (int s = 0; s < T_STEPS; s++) spk_pat[s] = 8'h08;
        run_window(200);
        expect_res("t3b", 3, 16, 3, 7, 0);
        tick();

        // watchdog: step 4 never completes
        for (int s = 0; s < T_STEPS; s++) spk_pat[s] = (s < 4) ? 8'h10 : 8'h01;
        withhold_at = 4;
        run_window(300);
        check("t4_timeout_latency", res_cyc - last_step_cyc, 73);
        expect_res("t4", 4, 4, 4, 4, 1);
        check("t4_steps", n_step - base_step, 5);
        withhold_at = -1;
        tick();

        // input gaps, slow core, held result with start pulses
        for (int s = 0; s < T_STEPS; s++)
            spk_pat[s] = ((s % 3 == 0) ? 8'h80 : 8'h00) | ((s < 5) ? 8'h01 : 8'h00);
        gap = 3; done_dly = 2; res_ready = 1'b0;
        run_window(400);
        for (int k = 0; k < 10; k++) begin
            start = k[0];
            tick();
        end
        start = 1'b0;
        check("t5_still_valid", res_valid, 1);
        expect_res("t5", 7, 6, 7, 6, 0);
        check("t5_steps", n_step - base_step, 16);
        res_ready = 1'b1;
        tick(); tick();
        check("t5_idle_busy", busy, 0);
        gap = 0; done_dly = 1;

        // abort while waiting on the core
        done_dly = 6; pend = 0; resp_idx = 0; seen = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100 && seen < 2; k++) begin
            tick();
            if (core_step) seen++;
        end
        check("t6_step_wait", seen, 2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_abort_busy", busy, 0);
        check("t6_abort_valid", res_valid, 0);
        repeat (8) tick();
        done_dly = 1;

        // reset while waiting for input
        in_hold = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t6_in_wait", in_ready, 1);
        rstb = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_in_ready", in_ready, 0);
        check("t6_rst_core_in", core_in, 0);
        tick();
        rstb = 1'b1;
        in_hold = 0; pend = 0;
        tick();

        for (int s = 0; s < T_STEPS; s++) spk_pat[s] = 8'h20 | ((s % 2 == 0) ? 8'h04 : 8'h00);
        run_window(200);
        expect_res("t6", 5, 16, 2, 7, 0);
        check("t6_steps", n_step - base_step, 16);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
